// File: rtl/aes_pkg.sv
// Shared AES types, round constants and forward S-box table.
// Used by the key-expansion engine and its SubWord block.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } kx_state_e;

  localparam int      NUM_RK  = 11;
  localparam rk_idx_t LAST_RK = 4'(NUM_RK - 1);

  // Padded to 16 entries so any 4-bit round index is legal.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] rcon(input rk_idx_t r);
    return RCON[r];
  endfunction

endpackage

// File: rtl/aes_sbox_fwd_word.sv
// Combinational forward SubWord: four parallel byte lookups.
// Counterpart of the inverse word-substitution block.
module aes_sbox_fwd_word
  import aes_pkg::*;
(
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);

  assign w_o = {
    sbox(w_i[31:24]),
    sbox(w_i[23:16]),
    sbox(w_i[15:8]),
    sbox(w_i[7:0])
  };

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule with an 11-entry round-key store.
// KEXP_SBOX_REG_EN: register SubWord output, two cycles per round.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  kx_state_e state_q;
  rk_idx_t   round_q;
  block_t    w_q;
  block_t    rk_q [NUM_RK];
  block_t    rd_q;
  logic      done_q;
  logic      valid_q;

  word_t  rot_w;
  word_t  sub_w;
  word_t  temp_d;
  word_t  w0_d, w1_d, w2_d, w3_d;
  block_t blk_d;
  logic   step_d;

`ifdef KEXP_SBOX_REG_EN
  word_t sub_q;
  logic  phase_q;
`endif

  assign rot_w = {w_q[23:0], w_q[31:24]};

  aes_sbox_fwd_word u_sub (
    .w_i (rot_w),
    .w_o (sub_w)
  );

  always_comb begin
`ifdef KEXP_SBOX_REG_EN
    temp_d = sub_q ^ {rcon(round_q), 24'h0};
    step_d = phase_q;
`else
    temp_d = sub_w ^ {rcon(round_q), 24'h0};
    step_d = 1'b1;
`endif
    w0_d  = w_q[127:96] ^ temp_d;
    w1_d  = w_q[95:64]  ^ w0_d;
    w2_d  = w_q[63:32]  ^ w1_d;
    w3_d  = w_q[31:0]   ^ w2_d;
    blk_d = {w0_d, w1_d, w2_d, w3_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      w_q     <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
`ifdef KEXP_SBOX_REG_EN
      sub_q   <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Store is read before this edge's write lands: no bypass.
      rd_q <= (rk_rd_idx <= LAST_RK) ? rk_q[rk_rd_idx] : '0;
      unique case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            rk_q[0] <= key_in;
            w_q     <= key_in;
            round_q <= 4'd1;
            valid_q <= 1'b0;
            state_q <= EXPAND;
`ifdef KEXP_SBOX_REG_EN
            phase_q <= 1'b0;
`endif
          end
        end
        EXPAND: begin
`ifdef KEXP_SBOX_REG_EN
          sub_q   <= sub_w;
          phase_q <= ~phase_q;
`endif
          if (step_d) begin
            rk_q[round_q] <= blk_d;
            w_q           <= blk_d;
            if (round_q == LAST_RK) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign rk_valid   = valid_q;
  assign rk_rd_data = rd_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero keys.
// Build with KEXP_SBOX_REG_EN to check the two-cycle-round variant.
module tb_aes_key_expand;

`ifdef KEXP_SBOX_REG_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 11;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic [3:0]   rk_rd_idx = '0;
  logic [127:0] rk_rd_data;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expand dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .rk_valid   (rk_valid),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  task automatic rd(input logic [3:0] i, output logic [127:0] d);
    @(negedge clk);
    rk_rd_idx = i;
    @(posedge clk);
    #1;
    d = rk_rd_data;
  endtask

  // Present a key for one edge; lat counts edges, accept edge = 1.
  task automatic run_key(input logic [127:0] k, output int lat);
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    key_valid = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    logic [127:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({key_ready, busy, done, rk_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1000",
               {key_ready, busy, done, rk_valid});
    end
    total++;
    if (rk_rd_data !== '0) begin
      bad++;
      $display("FAIL reset_rd: got %h want 0", rk_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      total++;
      if (d !== '0) begin
        bad++;
        $display("FAIL idle_rd[%0d]: got %h want 0", i, d);
      end
    end
    total++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      bad++;
      $display("FAIL idle_flags: got %b want 10", {key_ready, rk_valid});
    end
  endtask

  task automatic test_fips;
    int lat;
    logic [127:0] d;
    run_key(FIPS_KEY, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL fips_latency: got %0d want %0d", lat, LAT);
    end
    total++;
    if ({key_ready, busy, rk_valid} !== 3'b101) begin
      bad++;
      $display("FAIL fips_done_flags: got %b want 101",
               {key_ready, busy, rk_valid});
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL fips_done_pulse: got %b want 0", done);
    end
    rd(4'd1, d);
    total++;
    if (d !== fips_rk[1]) begin
      bad++;
      $display("FAIL fips_rk1: got %h want %h", d, fips_rk[1]);
    end
    rd(4'd10, d);
    total++;
    if (d !== fips_rk[10]) begin
      bad++;
      $display("FAIL fips_rk10: got %h want %h", d, fips_rk[10]);
    end
  endtask

  task automatic test_zero_key;
    int lat;
    logic [127:0] d;
    run_key('0, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
    end
    rd(4'd1, d);
    total++;
    if (d !== ZERO_RK1) begin
      bad++;
      $display("FAIL zero_rk1: got %h want %h", d, ZERO_RK1);
    end
    rd(4'd10, d);
    total++;
    if (d !== ZERO_RK10) begin
      bad++;
      $display("FAIL zero_rk10: got %h want %h", d, ZERO_RK10);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [127:0] d;
    @(negedge clk);
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    key_in = '0;
    n = 1;
    while (!done && n < 60) begin
      total++;
      if ({key_ready, busy} !== 2'b01) begin
        bad++;
        $display("FAIL hold_ready[%0d]: got %b want 01",
                 n, {key_ready, busy});
      end
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== LAT || rk_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_done: got lat=%0d valid=%b want %0d/1",
               n, rk_valid, LAT);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rk_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL restart_flags: got %b want 01", {rk_valid, busy});
    end
    @(negedge clk);
    key_valid = 1'b0;
    rk_rd_idx = 4'd10;
    @(posedge clk);
    #1;
    total++;
    if (rk_rd_data !== fips_rk[10]) begin
      bad++;
      $display("FAIL hold_first_rk10: got %h want %h",
               rk_rd_data, fips_rk[10]);
    end
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL restart_timeout: got done=%b want 1", done);
    end
    rd(4'd10, d);
    total++;
    if (d !== ZERO_RK10) begin
      bad++;
      $display("FAIL restart_rk10: got %h want %h", d, ZERO_RK10);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] d;
    @(negedge clk);
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({key_ready, busy, done, rk_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_flags: got %b want 1000",
               {key_ready, busy, done, rk_valid});
    end
    total++;
    if (rk_rd_data !== '0) begin
      bad++;
      $display("FAIL midrst_rd: got %h want 0", rk_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    total++;
    if ({rk_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_after: got %b want 00", {rk_valid, busy});
    end
    rd(4'd1, d);
    total++;
    if (d !== '0) begin
      bad++;
      $display("FAIL midrst_rk1: got %h want 0", d);
    end
  endtask

  task automatic test_read_sweep;
    int lat;
    logic [127:0] exp_v;
    logic [127:0] prev;
    run_key(FIPS_KEY, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL sweep_latency: got %0d want %0d", lat, LAT);
    end
    prev = '0;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i <= 10) ? fips_rk[i] : '0;
      @(negedge clk);
      rk_rd_idx = 4'(i);
      #1;
      if (i > 0) begin
        total++;
        if (rk_rd_data !== prev) begin
          bad++;
          $display("FAIL sweep_hold[%0d]: got %h want %h",
                   i, rk_rd_data, prev);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if (rk_rd_data !== exp_v) begin
        bad++;
        $display("FAIL sweep_rd[%0d]: got %h want %h",
                 i, rk_rd_data, exp_v);
      end
      prev = exp_v;
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_back_to_back();
    test_reset_mid();
    test_read_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
